alu_muldiv_seq: RTL and testbench

//  Multi-cycle sequencer for the ALU's long-latency ops (alu_mul, alu_div, alu_rem).
//  - Replaces the single-cycle a*b, a/b, a%b paths with an iterative shift-add multiplier
//    and a restoring divider, one bit per cycle.
//  - Sits beside the EX-stage alu. Drives busy to the hazard unit so IF/ID/EX stall

---
 rtl/alu_muldiv_seq_pkg.sv | 35 +++
 rtl/alu_muldiv_seq_if.sv | 33 +++
 rtl/alu_muldiv_seq_div_step.sv | 29 ++
 rtl/alu_muldiv_seq.sv | 149 ++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_muldiv_seq_pkg.sv
// +-------------------------------------------------------------------------+
// | alu_muldiv_seq_pkg                                                      |
// | Shared op codes and FSM state encodings for the long-latency ALU ops.   |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
`default_nettype none

package alu_muldiv_seq_pkg;

    localparam int c_op_w = 4;

    // Mirrors the alu_op codes and state encodings kept in para.v
    localparam logic [c_op_w-1:0] c_alu_mul = 4'd10;
    localparam logic [c_op_w-1:0] c_alu_div = 4'd11;
    localparam logic [c_op_w-1:0] c_alu_rem = 4'd12;

    localparam logic [1:0] c_msq_idle = 2'd0;
    localparam logic [1:0] c_msq_mul  = 2'd1;
    localparam logic [1:0] c_msq_div  = 2'd2;
    localparam logic [1:0] c_msq_done = 2'd3;

    typedef enum logic [1:0] {
        MSQ_IDLE = c_msq_idle,
        MSQ_MUL  = c_msq_mul,
        MSQ_DIV  = c_msq_div,
        MSQ_DONE = c_msq_done
    } msq_state_t;

    function automatic logic is_div_op(input logic [c_op_w-1:0] op);
        return (op == c_alu_div) || (op == c_alu_rem);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_muldiv_seq_if.sv
// +-------------------------------------------------------------------------+
// | alu_muldiv_seq_if                                                       |
// | Request/response handshake between the EX stage and the mul/div unit.   |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
`default_nettype none

interface alu_muldiv_seq_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, a, b, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, a, b, flush, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

`default_nettype wire

// File: rtl/alu_muldiv_seq_div_step.sv
// +-------------------------------------------------------------------------+
// | alu_muldiv_seq_div_step                                                 |
// | One combinational restoring-division step (one quotient bit).           |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
`default_nettype none

module alu_muldiv_seq_div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN:0]   rem_in,
    input  logic [XLEN-1:0] q_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_out,
    output logic [XLEN-1:0] q_out
);

    logic [XLEN+1:0] w_shift;
    logic            w_ge;

    assign w_shift = {rem_in, q_in[XLEN-1]};
    assign w_ge    = (w_shift >= {2'b00, divisor});
    // Partial remainder stays below 2*divisor, so the top bit never matters after subtract
    assign rem_out = w_ge ? (w_shift[XLEN:0] - {1'b0, divisor}) : w_shift[XLEN:0];
    assign q_out   = {q_in[XLEN-2:0], w_ge};

endmodule

`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
// +-------------------------------------------------------------------------+
// | alu_muldiv_seq                                                          |
// | Iterative mul/div/rem sequencer; FAST_MUL_EN selects single-cycle mul.  |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
`default_nettype none

module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input logic             clk,
    input logic             rst,
    alu_muldiv_seq_if.slave bus
);

    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(XLEN - 1);

    msq_state_t        r_state;
    msq_state_t        w_state_next;
    logic              w_accept;
    logic              w_last;
    logic [3:0]        r_op;
    // r_x/r_y/r_acc hold multiplicand/multiplier/product or quotient/divisor/remainder
    logic [XLEN-1:0]   r_x;
    logic [XLEN-1:0]   r_y;
    logic [XLEN:0]     r_acc;
    logic [CNT_W-1:0]  r_count;
    logic [XLEN-1:0]   r_result;
    logic [XLEN-1:0]   w_quick_result;
    logic [XLEN:0]     w_rem_out;
    logic [XLEN-1:0]   w_q_out;

    assign w_last = (r_count == c_last_iter);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MSQ_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            MSQ_IDLE: begin
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    if (bus.op == c_alu_mul) begin
`ifdef FAST_MUL_EN
                        w_state_next = MSQ_DONE;
`else
                        w_state_next = MSQ_MUL;
`endif
                    end else if (is_div_op(bus.op) && (bus.b != '0)) begin
                        w_state_next = MSQ_DIV;
                    end else begin
                        w_state_next = MSQ_DONE;
                    end
                end
            end
`ifndef FAST_MUL_EN
            MSQ_MUL:  if (w_last) w_state_next = MSQ_DONE;
`endif
            MSQ_DIV:  if (w_last) w_state_next = MSQ_DONE;
            MSQ_DONE: if (bus.out_ready) w_state_next = MSQ_IDLE;
            default:  w_state_next = MSQ_IDLE;
        endcase
        if (bus.flush) begin
            w_state_next = MSQ_IDLE;
            w_accept     = 1'b0;
        end
    end

    // Result for ops that reach DONE straight from IDLE
    always_comb begin
        w_quick_result = '0;
        if (bus.op == c_alu_mul) begin
`ifdef FAST_MUL_EN
            w_quick_result = bus.a * bus.b;
`endif
        end else if (bus.op == c_alu_div) begin
            w_quick_result = '1;
        end else if (bus.op == c_alu_rem) begin
            w_quick_result = bus.a;
        end
    end

    alu_muldiv_seq_div_step #(
        .XLEN (XLEN)
    ) u_div_step (
        .rem_in  (r_acc),
        .q_in    (r_x),
        .divisor (r_y),
        .rem_out (w_rem_out),
        .q_out   (w_q_out)
    );

`ifndef FAST_MUL_EN
    logic [XLEN-1:0] w_mul_acc;
    assign w_mul_acc = r_acc[XLEN-1:0] + (r_y[0] ? r_x : '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op     <= bus.op;
            r_x      <= bus.a;
            r_y      <= bus.b;
            r_acc    <= '0;
            r_count  <= '0;
            r_result <= w_quick_result;
        end else if (!bus.flush) begin
`ifndef FAST_MUL_EN
            if (r_state == MSQ_MUL) begin
                r_acc   <= {1'b0, w_mul_acc};
                r_x     <= r_x << 1;
                r_y     <= r_y >> 1;
                r_count <= r_count + 1'b1;
                if (w_last) r_result <= w_mul_acc;
            end
`endif
            if (r_state == MSQ_DIV) begin
                r_acc   <= w_rem_out;
                r_x     <= w_q_out;
                r_count <= r_count + 1'b1;
                if (w_last) r_result <= (r_op == c_alu_rem) ? w_rem_out[XLEN-1:0] : w_q_out;
            end
        end
    end

    assign bus.in_ready  = (r_state == MSQ_IDLE);
    assign bus.out_valid = (r_state == MSQ_DONE);
    assign bus.result    = r_result;
    assign bus.busy      = (r_state != MSQ_IDLE) && !(bus.out_valid && bus.out_ready);

endmodule

`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
// +-------------------------------------------------------------------------+
// | tb_alu_muldiv_seq                                                       |
// | Directed self-checking bench for alu_muldiv_seq (honours FAST_MUL_EN).  |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_alu_muldiv_seq;
    import alu_muldiv_seq_pkg::*;

    localparam int XLEN = 64;

`ifdef FAST_MUL_EN
    localparam int c_mul_lat = 0;
`else
    localparam int c_mul_lat = 64;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    alu_muldiv_seq_if #(.XLEN(XLEN)) bus ();

    alu_muldiv_seq #(
        .XLEN  (XLEN),
        .CNT_W (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one op for one cycle; returns at accept edge + 1
    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Edges after the accept edge until out_valid; busy must hold while waiting
    task automatic wait_done(output int lat, output logic busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (!bus.out_valid && lat < 200) begin
            if (!bus.busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    int          lat;
    logic        busy_ok;
    logic        stable;
    logic        seen_valid;
    logic [63:0] held;

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.op       = '0;
        bus.a        = '0;
        bus.b        = '0;
        bus.flush    = 1'b0;
        bus.out_ready = 1'b1;
        #22;
        rst = 1'b0;
        @(posedge clk);
        #1;

        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_result", bus.result, 64'd0);

        issue(c_alu_mul, 64'd7, 64'd6);
        wait_done(lat, busy_ok);
        chk("mul_latency", 64'(lat), 64'(c_mul_lat));
        chk("mul_result", bus.result, 64'd42);
        chk("mul_busy_released", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        chk("mul_back_idle", 64'({bus.in_ready, bus.out_valid}), 64'b10);

        issue(c_alu_div, 64'd100, 64'd7);
        wait_done(lat, busy_ok);
        chk("div_latency", 64'(lat), 64'd64);
        chk("div_busy_held", 64'(busy_ok), 64'd1);
        chk("div_result", bus.result, 64'd14);
        @(posedge clk);
        #1;

        issue(c_alu_rem, 64'd100, 64'd7);
        wait_done(lat, busy_ok);
        chk("rem_latency", 64'(lat), 64'd64);
        chk("rem_result", bus.result, 64'd2);
        @(posedge clk);
        #1;

        // Divide by zero lands in DONE in the cycle right after the accept cycle
        issue(c_alu_div, 64'd5, 64'd0);
        chk("div0_valid", 64'(bus.out_valid), 64'd1);
        chk("div0_result", bus.result, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk);
        #1;
        issue(c_alu_rem, 64'd5, 64'd0);
        chk("rem0_valid", 64'(bus.out_valid), 64'd1);
        chk("rem0_result", bus.result, 64'd5);
        @(posedge clk);
        #1;

        bus.out_ready = 1'b0;
        issue(c_alu_mul, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        wait_done(lat, busy_ok);
        chk("mulbig_latency", 64'(lat), 64'(c_mul_lat));
        chk("mulbig_result", bus.result, 64'hFFFF_FFFF_FFFF_FFFE);
        held   = bus.result;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (!bus.out_valid || bus.result !== held || !bus.busy || bus.in_ready) stable = 1'b0;
        end
        chk("backpressure_stable", 64'(stable), 64'd1);
        bus.out_ready = 1'b1;
        #1;
        chk("consume_busy_low", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        chk("consume_idle", 64'({bus.in_ready, bus.out_valid}), 64'b10);

        bus.out_ready = 1'b0;
        issue(4'd0, 64'd5, 64'd5);
        chk("other_op_valid", 64'(bus.out_valid), 64'd1);
        chk("other_op_result", bus.result, 64'd0);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush_done_idle", 64'({bus.in_ready, bus.out_valid}), 64'b10);
        bus.out_ready = 1'b1;

        issue(c_alu_div, 64'd1000, 64'd3);
        repeat (30) @(posedge clk);
        #1;
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.op       = c_alu_mul;
        bus.a        = 64'd1;
        bus.b        = 64'd1;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_div_idle", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
        seen_valid = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen_valid = 1'b1;
        end
        chk("flush_no_valid", 64'(seen_valid), 64'd0);

        issue(c_alu_mul, 64'd3, 64'd3);
        wait_done(lat, busy_ok);
        chk("mul3_result", bus.result, 64'd9);
        @(posedge clk);
        #1;

        issue(c_alu_div, 64'd1000, 64'd7);
        repeat (20) @(posedge clk);
        #1;
        chk("pre_reset_busy", 64'(bus.busy), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
        chk("async_reset_result", bus.result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_in_ready", 64'(bus.in_ready), 64'd1);

        issue(c_alu_div, 64'd100, 64'd7);
        wait_done(lat, busy_ok);
        chk("post_reset_div", bus.result, 64'd14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
